// File: rtl/shot_clock_ctrl.sv
// -----------------------------------------------------------------------------
// shot_clock_ctrl
//
// Control FSM for a basketball shot clock. It turns debounced push-button
// levels into one-cycle request edges and drives an external 5-bit countdown
// counter through reload/pause/mode lines. It also times the expiry horn.
//
// Parameters
//   BUZZ_CYCLES  horn-on duration in clk cycles (default 2 s at 50 MHz)
//
// Ports
//   clk          system clock; all logic is on its rising edge
//   rst          asynchronous active-low reset
//   start_btn    debounced level; each rising edge is a start request
//   stop_btn     debounced level; each rising edge is a stop request
//   reload_btn   debounced level; each rising edge is a reload request
//   mode_sw      0 selects 24 s, 1 selects 30 s (sampled only while idle)
//   count        current value of the external countdown counter
//   ctr_rst      synchronous active-high reload to the counter
//   ctr_pause    counter pause
//   ctr_mode     latched mode to the counter
//   buzzer       horn drive
//   state        FSM state (00 idle, 01 run, 10 pause, 11 expire)
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module shot_clock_ctrl #(
    parameter int unsigned BUZZ_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       reload_btn,
    input  logic       mode_sw,
    input  logic [4:0] count,
    output logic       ctr_rst,
    output logic       ctr_pause,
    output logic       ctr_mode,
    output logic       buzzer,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StPause  = 2'b10,
        StExpire = 2'b11
    } state_e;

    // Terminal timer value; a zero-length buzz degenerates to a single cycle.
    localparam logic [31:0] BuzzLast =
        (BUZZ_CYCLES == 0) ? 32'd0 : 32'(BUZZ_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------------
    logic start_prev_q;
    logic stop_prev_q;
    logic reload_prev_q;
    // Low for the first cycle after reset release. This keeps a button that
    // is already held high from looking like a fresh press.
    logic armed_q;

    logic start_edge;
    logic stop_edge;
    logic reload_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_prev_q  <= 1'b0;
            stop_prev_q   <= 1'b0;
            reload_prev_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            start_prev_q  <= start_btn;
            stop_prev_q   <= stop_btn;
            reload_prev_q <= reload_btn;
            armed_q       <= 1'b1;
        end
    end

    assign start_edge  = armed_q & start_btn  & ~start_prev_q;
    assign stop_edge   = armed_q & stop_btn   & ~stop_prev_q;
    assign reload_edge = armed_q & reload_btn & ~reload_prev_q;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_e      state_q, state_d;
    logic        ctr_rst_q, ctr_rst_d;
    logic        ctr_pause_q, ctr_pause_d;
    logic        ctr_mode_q, ctr_mode_d;
    logic        buzzer_q, buzzer_d;
    logic [31:0] timer_q, timer_d;
    logic        reload_pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ctr_rst_q   <= 1'b1;
            ctr_pause_q <= 1'b1;
            ctr_mode_q  <= 1'b0;
            buzzer_q    <= 1'b0;
            timer_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            ctr_rst_q   <= ctr_rst_d;
            ctr_pause_q <= ctr_pause_d;
            ctr_mode_q  <= ctr_mode_d;
            buzzer_q    <= buzzer_d;
            timer_q     <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        reload_pulse = 1'b0;
        case (state_q)
            StIdle: begin
                // A reload here just keeps us idle, so only start matters.
                if (start_edge) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Reload beats expiry, and expiry beats stop.
                if (reload_edge) begin
                    reload_pulse = 1'b1;
                end else if (count == 5'd0) begin
                    state_d = StExpire;
                end else if (stop_edge) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (reload_edge) begin
                    reload_pulse = 1'b1;
                end
                if (start_edge) begin
                    state_d = StRun;
                end
            end
            StExpire: begin
                if (reload_edge) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and horn-timer next values, derived from the state being entered
    // so that the flops present them together with the new state.
    always_comb begin
        ctr_rst_d   = (state_d == StIdle) | reload_pulse;
        ctr_pause_d = (state_d != StRun);
        // Mode tracks the switch only while idle and is frozen otherwise.
        ctr_mode_d  = (state_q == StIdle) ? mode_sw : ctr_mode_q;
        timer_d     = timer_q;
        buzzer_d    = 1'b0;
        if (state_d == StExpire) begin
            if (state_q != StExpire) begin
                timer_d  = 32'd0;
                buzzer_d = 1'b1;
            end else if (timer_q == BuzzLast) begin
                // Saturate: the horn stays off for the rest of the expiry.
                buzzer_d = 1'b0;
            end else begin
                timer_d  = timer_q + 32'd1;
                buzzer_d = 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign ctr_rst   = ctr_rst_q;
    assign ctr_pause = ctr_pause_q;
    assign ctr_mode  = ctr_mode_q;
    assign buzzer    = buzzer_q;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shot_clock_ctrl
//
// Scoreboard bench for shot_clock_ctrl. The driver applies inputs on the
// falling clock edge. It advances a reference model of the shot clock rules
// and pushes the outputs the DUT must show after the next rising edge, or
// straight after an asynchronous reset. A separate monitor pops and compares
// the outputs every time they can change. The countdown counter is modelled
// in the bench, and it is driven from the model's own control outputs.
// -----------------------------------------------------------------------------
module tb_shot_clock_ctrl;

    localparam int unsigned BUZZ = 20;
    localparam int PH_IDLE   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_PAUSE  = 2;
    localparam int PH_EXPIRE = 3;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       start_btn  = 1'b0;
    logic       stop_btn   = 1'b0;
    logic       reload_btn = 1'b0;
    logic       mode_sw    = 1'b0;
    logic [4:0] count      = 5'd0;
    logic       ctr_rst;
    logic       ctr_pause;
    logic       ctr_mode;
    logic       buzzer;
    logic [1:0] state;

    shot_clock_ctrl #(.BUZZ_CYCLES(BUZZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .reload_btn (reload_btn),
        .mode_sw    (mode_sw),
        .count      (count),
        .ctr_rst    (ctr_rst),
        .ctr_pause  (ctr_pause),
        .ctr_mode   (ctr_mode),
        .buzzer     (buzzer),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       rs;
        logic       pa;
        logic       md;
        logic       bz;
    } outs_t;

    outs_t exp_q[$];
    string tag_q[$];
    string tag    = "init";
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    // Reference model state
    int m_phase     = PH_IDLE;
    bit m_pulse     = 1'b0;   // reload pulse being shown this cycle
    bit m_mode      = 1'b0;
    int m_buzz_left = 0;      // horn cycles still owed
    int last_s      = -1;     // -1: no sample since reset release
    int last_p      = -1;
    int last_r      = -1;
    int m_count     = 0;

    function automatic outs_t model_outs();
        outs_t o;
        o.st = 2'(m_phase);
        o.rs = (m_phase == PH_IDLE) || m_pulse;
        o.pa = (m_phase != PH_RUN);
        o.md = m_mode;
        o.bz = (m_phase == PH_EXPIRE) && (m_buzz_left > 0);
        return o;
    endfunction

    task automatic model_reset();
        m_phase     = PH_IDLE;
        m_pulse     = 1'b0;
        m_mode      = 1'b0;
        m_buzz_left = 0;
        last_s      = -1;
        last_p      = -1;
        last_r      = -1;
    endtask

    // Advance the model across one rising edge, using the inputs now applied.
    task automatic model_step();
        outs_t cur;
        int    cnt_next;
        bit    se, pe, re;
        int    ph;
        cur = model_outs();
        if (cur.rs)                        cnt_next = cur.md ? 30 : 24;
        else if (!cur.pa && m_count != 0)  cnt_next = m_count - 1;
        else                               cnt_next = m_count;
        if (!rst) begin
            model_reset();
        end else begin
            se = (start_btn == 1'b1)  && (last_s == 0);
            pe = (stop_btn == 1'b1)   && (last_p == 0);
            re = (reload_btn == 1'b1) && (last_r == 0);
            ph = m_phase;
            m_pulse = 1'b0;
            if (ph == PH_IDLE) m_mode = mode_sw;
            if (ph == PH_IDLE) begin
                if (se) m_phase = PH_RUN;
            end else if (ph == PH_RUN) begin
                if (re) m_pulse = 1'b1;
                else if (m_count == 0) begin
                    m_phase     = PH_EXPIRE;
                    m_buzz_left = int'(BUZZ);
                end else if (pe) m_phase = PH_PAUSE;
            end else if (ph == PH_PAUSE) begin
                if (re) m_pulse = 1'b1;
                if (se) m_phase = PH_RUN;
            end else begin
                if (re) begin
                    m_phase     = PH_IDLE;
                    m_buzz_left = 0;
                end else if (m_buzz_left > 0) begin
                    m_buzz_left = m_buzz_left - 1;
                end
            end
            last_s = int'(start_btn);
            last_p = int'(stop_btn);
            last_r = int'(reload_btn);
        end
        exp_q.push_back(model_outs());
        tag_q.push_back(tag);
        m_count = cnt_next;
    endtask

    // One clock: called on a falling edge, returns on the next falling edge.
    task automatic cycle(input bit s, input bit p, input bit r);
        start_btn  = s;
        stop_btn   = p;
        reload_btn = r;
        count      = 5'(m_count);
        model_step();
        @(negedge clk);
    endtask

    task automatic press(input bit s, input bit p, input bit r);
        cycle(s, p, r);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int v);
        int n;
        n = 0;
        while (m_count != v && n < 64) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (m_count != v) begin
            checks++;
            errors++;
            $display("FAIL %s_count_wait: count=%0d required=%0d", tag, m_count, v);
        end
    endtask

    // Assert reset between clock edges and hold it, keeping buttons as they are.
    task automatic async_reset(input int hold);
        #1;
        model_reset();
        exp_q.push_back(model_outs());
        tag_q.push_back({tag, "_async_rst"});
        rst = 1'b0;
        for (int i = 0; i < hold; i++) cycle(start_btn, stop_btn, reload_btn);
        rst = 1'b1;
    endtask

    // Monitor: outputs can change on a rising clock edge or on reset assertion.
    initial begin
        outs_t e;
        outs_t got;
        string t;
        forever begin
            @(posedge clk or negedge rst);
            #2;
            if (mon_en) begin
                got = outs_t'({state, ctr_rst, ctr_pause, ctr_mode, buzzer});
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL no_expected_entry: got st=%b rst=%b pause=%b mode=%b buzz=%b",
                             got.st, got.rs, got.pa, got.md, got.bz);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display({"FAIL %s @%0t: got st=%b rst=%b pause=%b mode=%b buzz=%b,",
                                  " required st=%b rst=%b pause=%b mode=%b buzz=%b"},
                                 t, $time, got.st, got.rs, got.pa, got.md, got.bz,
                                 e.st, e.rs, e.pa, e.md, e.bz);
                    end
                end
            end
        end
    end

    initial begin
        bit s_lvl, p_lvl, r_lvl;
        @(negedge clk);
        mon_en = 1'b1;

        tag = "reset_hold";
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        tag = "idle_mode30";
        mode_sw = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        tag = "start_from_idle";
        press(1'b1, 1'b0, 1'b0);

        tag = "run_to_17";
        run_until(17);
        tag = "stop_at_17";
        press(1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        tag = "resume";
        press(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        tag = "reload_stop_same";
        run_until(9);
        press(1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        tag = "pause_reload";
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        tag = "pause_start_reload";
        press(1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        tag = "expire_buzz";
        run_until(0);
        repeat (BUZZ + 4) cycle(1'b0, 1'b0, 1'b0);
        tag = "expire_ignore";
        press(1'b1, 1'b1, 1'b0);
        tag = "expire_reload";
        press(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        tag = "mode_frozen";
        mode_sw = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        mode_sw = 1'b1;
        run_until(0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        tag = "reload_midbuzz";
        press(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        tag = "reset_midbuzz";
        press(1'b1, 1'b0, 1'b0);
        run_until(0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        async_reset(3);
        tag = "held_start_after_rst";
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        tag = "restart_after_rst";
        cycle(1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        tag = "random";
        s_lvl = 1'b0;
        p_lvl = 1'b0;
        r_lvl = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 249) == 0) async_reset(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 29) == 0) mode_sw = ~mode_sw;
            if ($urandom_range(0, 9) == 0)  s_lvl = ~s_lvl;
            if ($urandom_range(0, 19) == 0) p_lvl = ~p_lvl;
            if ($urandom_range(0, 23) == 0) r_lvl = ~r_lvl;
            cycle(s_lvl, p_lvl, r_lvl);
        end

        tag = "drain";
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shot_clock_ctrl.md
SHOT_CLOCK_CTRL -- requirements
Module: shot_clock_ctrl

Interface
REQ-001 The block SHALL have parameter BUZZ_CYCLES, default 100000000, giving the buzzer-on duration in clk cycles (2 s at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the 50 MHz system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start_btn, input, 1 bit: debounced, clk-synchronous level; each rising edge is a start request.
REQ-005 The block SHALL have port stop_btn, input, 1 bit: debounced, synchronous level; each rising edge is a stop request.
REQ-006 The block SHALL have port reload_btn, input, 1 bit: debounced, synchronous level; each rising edge is a reload request.
REQ-007 The block SHALL have port mode_sw, input, 1 bit: 0 selects 24 s, 1 selects 30 s.
REQ-008 The block SHALL have port count, input, 5 bits: the current value of the countdown counter.
REQ-009 The block SHALL have port ctr_rst, output, 1 bit: synchronous active-high reload to the counter.
REQ-010 The block SHALL have port ctr_pause, output, 1 bit: counter pause.
REQ-011 The block SHALL have port ctr_mode, output, 1 bit: latched mode to the counter.
REQ-012 The block SHALL have port buzzer, output, 1 bit: horn drive.
REQ-013 The block SHALL have port state, output, 2 bits: FSM state encoding for display/debug.

Function
REQ-014 Button edge detection SHALL use one registered copy per button; edge = input high AND previous sample low, one cycle wide.
REQ-015 FSM states SHALL be IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, EXPIRE=2'b11; the state output SHALL equal the current state register.
REQ-016 In IDLE, ctr_rst=1, ctr_pause=1, buzzer=0, and ctr_mode SHALL load mode_sw every cycle.
REQ-017 Outside IDLE, ctr_mode SHALL hold its value; mode_sw changes SHALL be ignored until the next IDLE.
REQ-018 IDLE SHALL go to RUN on a start edge, and to IDLE on a reload edge; stop edges SHALL be ignored.
REQ-019 In RUN, ctr_rst=0 and ctr_pause=0, except that a reload edge SHALL produce exactly one cycle of ctr_rst=1 on the following cycle while staying in RUN.
REQ-020 RUN SHALL go to EXPIRE when count==5'd0 with no reload edge in that cycle.
REQ-021 RUN SHALL go to PAUSE on a stop edge with count!=0 and no reload edge.
REQ-022 Priority within a cycle in RUN SHALL be reload > expiry (count==0) > stop; start edges SHALL be ignored in RUN.
REQ-023 In PAUSE, ctr_pause=1; a start edge SHALL return to RUN.
REQ-024 In PAUSE, a reload edge SHALL give a one-cycle ctr_rst pulse and stay in PAUSE; if start and reload coincide, reload SHALL be pulsed and the FSM SHALL go to RUN.
REQ-025 On entry to EXPIRE, ctr_pause SHALL be 1 from the next cycle, buzzer=1, and a buzzer timer SHALL be cleared.
REQ-026 In EXPIRE, buzzer SHALL stay high for exactly BUZZ_CYCLES cycles, then go to 0; the timer SHALL saturate and not wrap.
REQ-027 EXPIRE SHALL go to IDLE on a reload edge, and buzzer SHALL clear in the same transition even if the timer is mid-count; start and stop edges SHALL be ignored.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-029 The buzzer timer SHALL be 32 bits wide, with terminal compare at BUZZ_CYCLES-1.

Reset
REQ-030 While rst=0, the block SHALL force state=IDLE, ctr_rst=1, ctr_pause=1, ctr_mode=0, buzzer=0, buzzer timer=0, and edge registers=0, asynchronously.
REQ-031 Reset asserted mid-operation, including mid-buzz, SHALL take effect immediately; on release, the block SHALL start in IDLE with no spurious edge detected from buttons already held high.

Verification (BUZZ_CYCLES=20, counter model included)
REQ-032 Reset then mode_sw=1, start edge -> state=01, ctr_mode=1, ctr_rst=0 one cycle later, count decrements from 30.
REQ-033 Drive count to 0 in RUN -> state=11 next cycle, buzzer=1 for exactly 20 cycles then 0, ctr_pause=1; reload edge -> state=00.
REQ-034 Stop edge in RUN at count=17 -> state=10, ctr_pause=1, count holds 17; start edge -> RUN, count resumes from 17.
REQ-035 Reload and stop edges in the same cycle in RUN at count=9 -> one ctr_rst pulse, state stays 01.
REQ-036 Toggle mode_sw from 0 to 1 during RUN -> ctr_mode stays 0; after reload edge in EXPIRE to IDLE -> ctr_mode=1.
REQ-037 rst low at buzzer cycle 10 with start_btn held high -> buzzer=0 and state=00 immediately; after release, no RUN entry until start_btn falls and rises again.
